// File: rtl/user_demux_rd.sv
// user_demux_rd: routes one AXI-Stream input to one of N_ID outputs, one
// descriptor (dest + byte length) at a time. Beat count comes only from the
// descriptor length; s_axis_tlast is forwarded but never used for framing.
// Optional build macro USER_DEMUX_TLAST_CHK_EN adds a one-cycle err pulse when
// the incoming tlast disagrees with the descriptor-derived last beat.
//
// Handshake rule (all ports): a transfer happens on a rising edge where valid
// and ready are both 1; valid, once raised, holds with its payload stable until
// that transfer. Ready may depend combinationally on valid of the same channel.
module user_demux_rd #(
  parameter int DATA_BITS = 512,
  parameter int N_ID      = 4,
  parameter int LEN_BITS  = 28,
  parameter int DEST_BITS = 4,
  parameter int PID_BITS  = 6
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  // descriptor channel
  input  logic                                  mux_valid,
  output logic                                  mux_ready,
  input  logic [DEST_BITS+LEN_BITS-1:0]         mux_data,
  // input stream
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [DATA_BITS-1:0]                  s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]                s_axis_tkeep,
  input  logic [PID_BITS-1:0]                   s_axis_tid,
  input  logic                                  s_axis_tlast,
  // per-destination output streams
  output logic [N_ID-1:0]                       m_axis_tvalid,
  input  logic [N_ID-1:0]                       m_axis_tready,
  output logic [N_ID-1:0][DATA_BITS-1:0]        m_axis_tdata,
  output logic [N_ID-1:0][DATA_BITS/8-1:0]      m_axis_tkeep,
  output logic [N_ID-1:0][PID_BITS-1:0]         m_axis_tid,
  output logic [N_ID-1:0]                       m_axis_tlast,
  // status
  output logic                                  err,
  output logic                                  o_dbg_state
);

  localparam int BYTES    = DATA_BITS / 8;
  localparam int BLOG     = $clog2(BYTES);
  localparam int CNT_BITS = LEN_BITS - BLOG;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DEMUX = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [DEST_BITS-1:0]  r_dest;
  logic                  r_rst_q;

  logic [DEST_BITS-1:0]  w_dest;
  logic [LEN_BITS-1:0]   w_len;
  logic [LEN_BITS-1:0]   w_len_m1;
  logic [CNT_BITS-1:0]   w_beats_m1;
  logic                  w_len_nz;
  logic                  w_demux;
  logic                  w_hs;
  logic                  w_last_beat;
  logic                  w_tr_done;
  logic                  w_desc_acc;
  logic                  w_sel_hit;

  // Descriptor decode: beats-1 = (len-1) / bytes-per-beat, valid only for len != 0
  assign w_dest     = mux_data[DEST_BITS-1:0];
  assign w_len      = mux_data[DEST_BITS +: LEN_BITS];
  assign w_len_nz   = |w_len;
  assign w_len_m1   = w_len - LEN_BITS'(1);
  assign w_beats_m1 = w_len_m1[LEN_BITS-1:BLOG];

  // Reset gates everything combinationally so nothing leaks out in the reset cycle
  assign w_demux     = (r_state == ST_DEMUX) && !areset;
  assign w_hs        = s_axis_tvalid && s_axis_tready;
  assign w_last_beat = (r_cnt == '0);
  assign w_tr_done   = w_demux && w_hs && w_last_beat;
  // r_rst_q holds off descriptor acceptance for one cycle after reset releases
  assign mux_ready   = !areset && !r_rst_q && ((r_state == ST_IDLE) || w_tr_done);
  assign w_desc_acc  = mux_valid && mux_ready;

  assign o_dbg_state = r_state;

  // Control FSM: descriptor load, beat countdown, back-to-back reload on the last beat
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dest  <= '0;
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // zero-length descriptors are consumed here and leave the FSM idle
          if (w_desc_acc && w_len_nz) begin
            r_dest  <= w_dest;
            r_cnt   <= w_beats_m1;
            r_state <= ST_DEMUX;
          end
        end
        ST_DEMUX: begin
          if (w_hs) begin
            if (w_last_beat) begin
              if (w_desc_acc && w_len_nz) begin
                r_dest <= w_dest;
                r_cnt  <= w_beats_m1;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - CNT_BITS'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: zero-latency steering of the input stream to the selected output
  always_comb begin
    m_axis_tvalid = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tid    = '0;
    m_axis_tlast  = '0;
    s_axis_tready = 1'b0;
    w_sel_hit     = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      if (w_demux && (r_dest == DEST_BITS'(i))) begin
        w_sel_hit        = 1'b1;
        m_axis_tvalid[i] = s_axis_tvalid;
        m_axis_tdata[i]  = s_axis_tdata;
        m_axis_tkeep[i]  = s_axis_tkeep;
        m_axis_tid[i]    = s_axis_tid;
        m_axis_tlast[i]  = s_axis_tlast;
        s_axis_tready    = m_axis_tready[i];
      end
    end
    // out-of-range destination: swallow the beats so the input never stalls
    if (w_demux && !w_sel_hit) begin
      s_axis_tready = 1'b1;
    end
  end

`ifdef USER_DEMUX_TLAST_CHK_EN
  logic r_err;

  // tlast check: flag any accepted beat whose tlast disagrees with the countdown
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_demux && w_hs && (s_axis_tlast != w_last_beat);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_user_demux_rd.sv
// Directed bench for user_demux_rd (N_ID=4, DATA_BITS=512).
module tb_user_demux_rd;

  localparam int DW  = 512;
  localparam int NID = 4;
  localparam int LB  = 28;
  localparam int DB  = 4;
  localparam int PB  = 6;
  localparam int KW  = DW / 8;
  localparam int SW  = 36;

  logic                       aclk;
  logic                       areset;
  logic                       mux_valid;
  logic                       mux_ready;
  logic [DB+LB-1:0]           mux_data;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [DW-1:0]              s_axis_tdata;
  logic [KW-1:0]              s_axis_tkeep;
  logic [PB-1:0]              s_axis_tid;
  logic                       s_axis_tlast;
  logic [NID-1:0]             m_axis_tvalid;
  logic [NID-1:0]             m_axis_tready;
  logic [NID-1:0][DW-1:0]     m_axis_tdata;
  logic [NID-1:0][KW-1:0]     m_axis_tkeep;
  logic [NID-1:0][PB-1:0]     m_axis_tid;
  logic [NID-1:0]             m_axis_tlast;
  logic                       err;
  logic                       o_dbg_state;

  user_demux_rd #(
    .DATA_BITS(DW), .N_ID(NID), .LEN_BITS(LB), .DEST_BITS(DB), .PID_BITS(PB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_data(mux_data),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .err(err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [SW-1:0] exp_q[$];
  int beats_seen[NID];
  int s_hs_cnt   = 0;
  int err_cnt    = 0;
  int any_valid  = 0;
  int hs_cyc[$];
  int acc_cyc[$];
  bit mirror_on  = 1'b0;

  always @(negedge aclk) begin
    logic [SW-1:0] g;
    logic [SW-1:0] e;
    if (!areset) begin
      if (s_axis_tvalid && s_axis_tready) begin
        s_hs_cnt++;
        hs_cyc.push_back(cyc);
      end
      if (err) err_cnt++;
      if (|m_axis_tvalid) any_valid++;
      if (mirror_on && o_dbg_state) check_eq("tready_mirror", s_axis_tready, m_axis_tready[0]);
      for (int i = 0; i < NID; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          g = {4'(i), m_axis_tdata[i][31:0]};
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          check_eq("beat", g, e);
          check_eq("beat_tid", m_axis_tid[i], s_axis_tid);
          check_eq("beat_tlast", m_axis_tlast[i], s_axis_tlast);
          beats_seen[i]++;
        end else if (!m_axis_tvalid[i]) begin
          check_eq("idle_zero", {m_axis_tdata[i][31:0], m_axis_tlast[i]}, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_desc(input int dest, input int len);
    int n;
    mux_data  = {LB'(len), DB'(dest)};
    mux_valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!mux_ready && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (!mux_ready) check_eq("desc_ready", mux_ready, 1);
    else acc_cyc.push_back(cyc);
    @(posedge aclk); #1;
    mux_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int base, input int lmask);
    int w;
    for (int k = 0; k < n; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {16{32'(base + k)}};
      s_axis_tlast  = lmask[k];
      w = 0;
      @(negedge aclk);
      while (!s_axis_tready && w < 200) begin
        w++;
        @(negedge aclk);
      end
      if (!s_axis_tready) check_eq("beat_ready", s_axis_tready, 1);
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  function automatic int seen_sum();
    int s = 0;
    for (int i = 0; i < NID; i++) s += beats_seen[i];
    return s;
  endfunction

  // ---------------- stimulus ----------------
  int b_sum, b_port, s0, v0, e0, exp_err;
  bit done;

  initial begin
    areset        = 1'b1;
    mux_valid     = 1'b0;
    mux_data      = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tid    = 6'h15;
    s_axis_tlast  = 1'b0;
    m_axis_tready = '1;
    for (int i = 0; i < NID; i++) beats_seen[i] = 0;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_mux_ready", mux_ready, 0);
    check_eq("rst_s_tready", s_axis_tready, 0);
    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_state", o_dbg_state, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_eq("post_rst_mux_ready", mux_ready, 0);
    @(negedge aclk);
    check_eq("idle_mux_ready", mux_ready, 1);
    @(posedge aclk); #1;

    // dest=2 len=256 -> 4 beats on port 2
    b_sum = seen_sum(); b_port = beats_seen[2];
    for (int k = 0; k < 4; k++) exp_q.push_back({4'd2, 32'h100 + 32'(k)});
    fork
      send_desc(2, 256);
      send_beats(4, 'h100, 'b1000);
    join
    @(negedge aclk);
    check_eq("t1_state_idle", o_dbg_state, 0);
    check_eq("t1_port2_beats", beats_seen[2] - b_port, 4);
    check_eq("t1_total_beats", seen_sum() - b_sum, 4);
    @(posedge aclk); #1;

    // len=100 -> 2 beats on port 1
    b_port = beats_seen[1];
    for (int k = 0; k < 2; k++) exp_q.push_back({4'd1, 32'h200 + 32'(k)});
    fork
      send_desc(1, 100);
      send_beats(2, 'h200, 'b10);
    join
    @(negedge aclk);
    check_eq("t2_port1_beats", beats_seen[1] - b_port, 2);
    @(posedge aclk); #1;

    // len=0 -> accepted, no beats, input held valid meanwhile
    s0 = s_hs_cnt;
    s_axis_tvalid = 1'b1;
    send_desc(3, 0);
    repeat (2) @(negedge aclk);
    check_eq("t2_len0_state", o_dbg_state, 0);
    check_eq("t2_len0_beats", s_hs_cnt - s0, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;

    // back-to-back: dest=1 len=64 then dest=3 len=128
    acc_cyc.delete(); hs_cyc.delete();
    exp_q.push_back({4'd1, 32'h300});
    exp_q.push_back({4'd3, 32'h310});
    exp_q.push_back({4'd3, 32'h311});
    fork
      begin send_desc(1, 64); send_desc(3, 128); end
      begin send_beats(1, 'h300, 'b1); send_beats(2, 'h310, 'b10); end
    join
    check_eq("t3_acc_cnt", acc_cyc.size(), 2);
    check_eq("t3_hs_cnt", hs_cyc.size(), 3);
    if (acc_cyc.size() == 2 && hs_cyc.size() == 3) begin
      check_eq("t3_acc_gap", acc_cyc[1] - acc_cyc[0], 1);
      check_eq("t3_acc_on_beat", acc_cyc[1], hs_cyc[0]);
      check_eq("t3_no_gap_a", hs_cyc[1] - hs_cyc[0], 1);
      check_eq("t3_no_gap_b", hs_cyc[2] - hs_cyc[1], 1);
    end

    // dest=0 len=512 with random m_axis_tready[0]
    b_port = beats_seen[0];
    for (int k = 0; k < 8; k++) exp_q.push_back({4'd0, 32'h400 + 32'(k)});
    done = 1'b0;
    mirror_on = 1'b1;
    fork
      begin
        fork
          send_desc(0, 512);
          send_beats(8, 'h400, 'h80);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          if (!done) m_axis_tready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    mirror_on = 1'b0;
    m_axis_tready[0] = 1'b1;
    @(negedge aclk);
    check_eq("t4_port0_beats", beats_seen[0] - b_port, 8);
    @(posedge aclk); #1;

    // dest=7 (out of range) len=128 -> 2 beats drained, no output valid
    s0 = s_hs_cnt; v0 = any_valid; b_sum = seen_sum();
    fork
      send_desc(7, 128);
      send_beats(2, 'h500, 'b10);
    join
    @(negedge aclk);
    check_eq("t5_drained", s_hs_cnt - s0, 2);
    check_eq("t5_no_valid", any_valid - v0, 0);
    check_eq("t5_no_beats", seen_sum() - b_sum, 0);
    check_eq("t5_state_idle", o_dbg_state, 0);
    @(posedge aclk); #1;

    // tlast on beats 1 and 3 of 3 -> one mismatch (beat 1)
`ifdef USER_DEMUX_TLAST_CHK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    e0 = err_cnt;
    for (int k = 0; k < 3; k++) exp_q.push_back({4'd1, 32'h600 + 32'(k)});
    fork
      send_desc(1, 192);
      send_beats(3, 'h600, 'b101);
    join
    repeat (2) @(negedge aclk);
    check_eq("t6_err_pulses", err_cnt - e0, exp_err);
    @(posedge aclk); #1;

    // reset in the middle of a 4-beat transfer
    for (int k = 0; k < 2; k++) exp_q.push_back({4'd0, 32'h700 + 32'(k)});
    fork
      send_desc(0, 256);
      send_beats(2, 'h700, 0);
    join
    check_eq("t7_mid_state", o_dbg_state, 1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {16{32'h702}};
    areset = 1'b1;
    @(negedge aclk);
    check_eq("t7_rst_mux_ready", mux_ready, 0);
    check_eq("t7_rst_s_tready", s_axis_tready, 0);
    check_eq("t7_rst_m_tvalid", m_axis_tvalid, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_eq("t7_after_state", o_dbg_state, 0);
    check_eq("t7_after_m_tvalid", m_axis_tvalid, 0);
    check_eq("t7_after_s_tready", s_axis_tready, 0);
    check_eq("t7_after_mux_ready", mux_ready, 0);
    check_eq("t7_after_err", err, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    @(negedge aclk);
    check_eq("t7_ready_again", mux_ready, 1);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
